turf_event_sequencer: RTL and testbench

Event sequencer in the memclk domain that drains the TURF header stream and the four per-TURFIO payload streams into a single event stream. For each event it forwards the complete header, then each unmasked TURFIO's payload in index order 0..3, with exactly one tlast on the last qword of the event. It sits between the header FIFO output and the event DMA/ethernet framer, and is the sole consumer of all five streams.

---
 rtl/turf_event_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_turf_event_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/turf_event_sequencer.sv
// turf_event_sequencer
// Drains the TURF header stream and the four per-TURFIO payload streams into
// one event stream: header first, then each unmasked TURFIO in index order,
// with a single tlast on the final qword of the event.
// Optional feature macro: EVENT_SEQ_TIMEOUT_EN (idle-source watchdog that
// substitutes a 0xBADD fill beat for a stalled TURFIO).
module turf_event_sequencer #(
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    memclk,
    input  logic                    memresetn,
    input  logic [DATA_WIDTH-1:0]   s_thdr_tdata,
    input  logic                    s_thdr_tvalid,
    output logic                    s_thdr_tready,
    input  logic                    s_thdr_tlast,
    input  logic [4*DATA_WIDTH-1:0] s_tio_tdata,
    input  logic [3:0]              s_tio_tvalid,
    output logic [3:0]              s_tio_tready,
    input  logic [3:0]              s_tio_tlast,
    input  logic [3:0]              tio_mask_i,
    output logic [DATA_WIDTH-1:0]   m_ev_tdata,
    output logic                    m_ev_tvalid,
    input  logic                    m_ev_tready,
    output logic                    m_ev_tlast,
    output logic                    busy_o,
    output logic [31:0]             event_count_o,
    output logic [3:0]              tio_timeout_o
);

`ifdef EVENT_SEQ_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_TIO, ST_FILL} state_t;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
`else
    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_TIO} state_t;
`endif

    state_t          state_q, state_d;
    logic [1:0]      cur_tio_q, cur_tio_d;
    logic [3:0]      mask_q, mask_d;
    logic [31:0]     count_q, count_d;

    logic [DATA_WIDTH-1:0] tio_data [4];
    logic [DATA_WIDTH-1:0] ev_tdata;
    logic                  ev_tvalid;
    logic                  ev_tlast;
    logic                  thdr_tready;
    logic [3:0]            tio_tready;
    logic [3:0]            eff_mask;
    logic [2:0]            first_unmasked;
    logic [2:0]            higher_unmasked;

    // Unpack the flat TURFIO data bus into one word per source
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_tio_unpack
            assign tio_data[gi] = s_tio_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Lowest unmasked index >= from, returned as {found, index}
    function automatic logic [2:0] find_unmasked(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if ((i >= int'(from)) && !mask[i]) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    // The mask applied to the header-tlast decision is the live input while
    // idle, because it is latched on that very first header beat.
    assign eff_mask        = (state_q == ST_IDLE) ? tio_mask_i : mask_q;
    assign first_unmasked  = find_unmasked(eff_mask, 3'd0);
    assign higher_unmasked = find_unmasked(mask_q, {1'b0, cur_tio_q} + 3'd1);

`ifdef EVENT_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]       timeout_q, timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
`endif

    // Next-state, source routing and tlast suppression
    always_comb begin
        state_d     = state_q;
        cur_tio_d   = cur_tio_q;
        mask_d      = mask_q;
        count_d     = count_q;
        ev_tdata    = '0;
        ev_tvalid   = 1'b0;
        ev_tlast    = 1'b0;
        thdr_tready = 1'b0;
        tio_tready  = 4'b0000;
`ifdef EVENT_SEQ_TIMEOUT_EN
        idle_cnt_d  = '0;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            ST_IDLE, ST_HEADER: begin
                ev_tdata    = s_thdr_tdata;
                ev_tvalid   = s_thdr_tvalid;
                ev_tlast    = s_thdr_tlast & ~first_unmasked[2];
                thdr_tready = m_ev_tready;
                if (s_thdr_tvalid && m_ev_tready) begin
                    if (state_q == ST_IDLE) begin
                        mask_d  = tio_mask_i;
                        state_d = ST_HEADER;
                    end
                    if (s_thdr_tlast) begin
                        if (first_unmasked[2]) begin
                            state_d   = ST_TIO;
                            cur_tio_d = first_unmasked[1:0];
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_TIO: begin
                ev_tdata              = tio_data[cur_tio_q];
                ev_tvalid             = s_tio_tvalid[cur_tio_q];
                ev_tlast              = s_tio_tlast[cur_tio_q] & ~higher_unmasked[2];
                tio_tready[cur_tio_q] = m_ev_tready;
                if (s_tio_tvalid[cur_tio_q] && m_ev_tready && s_tio_tlast[cur_tio_q]) begin
                    if (higher_unmasked[2]) begin
                        cur_tio_d = higher_unmasked[1:0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef EVENT_SEQ_TIMEOUT_EN
                // Any valid beat (including a switching handshake) restarts the watchdog
                if (!s_tio_tvalid[cur_tio_q]) begin
                    if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_d[cur_tio_q] = 1'b1;
                        state_d              = ST_FILL;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
`endif
            end
`ifdef EVENT_SEQ_TIMEOUT_EN
            ST_FILL: begin
                ev_tdata  = {16'hBADD, {(DATA_WIDTH-18){1'b0}}, cur_tio_q};
                ev_tvalid = 1'b1;
                ev_tlast  = ~higher_unmasked[2];
                if (m_ev_tready) begin
                    if (higher_unmasked[2]) begin
                        cur_tio_d = higher_unmasked[1:0];
                        state_d   = ST_TIO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (ev_tvalid && m_ev_tready && ev_tlast) begin
            count_d = count_q + 32'd1;
        end
    end

    // State registers; reset abandons any partial event
    always_ff @(posedge memclk) begin
        if (!memresetn) begin
            state_q   <= ST_IDLE;
            cur_tio_q <= 2'd0;
            mask_q    <= 4'h0;
            count_q   <= 32'd0;
`ifdef EVENT_SEQ_TIMEOUT_EN
            idle_cnt_q <= '0;
            timeout_q  <= 4'h0;
`endif
        end else begin
            state_q   <= state_d;
            cur_tio_q <= cur_tio_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
`ifdef EVENT_SEQ_TIMEOUT_EN
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // Outputs are forced to their idle values while reset is held
    assign m_ev_tdata    = memresetn ? ev_tdata : '0;
    assign m_ev_tvalid   = memresetn & ev_tvalid;
    assign m_ev_tlast    = memresetn & ev_tlast;
    assign s_thdr_tready = memresetn & thdr_tready;
    assign s_tio_tready  = memresetn ? tio_tready : 4'b0000;
    assign busy_o        = memresetn & (state_q != ST_IDLE);
    assign event_count_o = count_q;
`ifdef EVENT_SEQ_TIMEOUT_EN
    assign tio_timeout_o = memresetn ? timeout_q : 4'b0000;
`else
    assign tio_timeout_o = 4'b0000;
`endif

endmodule

// File: tb/tb_turf_event_sequencer.sv
// Self-checking bench for turf_event_sequencer. The reference model builds the
// expected event as a queue (header, then unmasked TURFIO payloads in order,
// single tlast at the end) and compares every m_ev handshake against it.
module tb_turf_event_sequencer;
    localparam int DW = 64;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } beat_t;

    logic            memclk = 1'b0;
    logic            memresetn;
    logic [DW-1:0]   s_thdr_tdata;
    logic            s_thdr_tvalid;
    logic            s_thdr_tready;
    logic            s_thdr_tlast;
    logic [4*DW-1:0] s_tio_tdata;
    logic [3:0]      s_tio_tvalid;
    logic [3:0]      s_tio_tready;
    logic [3:0]      s_tio_tlast;
    logic [3:0]      tio_mask_i;
    logic [DW-1:0]   m_ev_tdata;
    logic            m_ev_tvalid;
    logic            m_ev_tready;
    logic            m_ev_tlast;
    logic            busy_o;
    logic [31:0]     event_count_o;
    logic [3:0]      tio_timeout_o;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;
    int cyc;

    logic [63:0] hq[$];
    logic [63:0] tq[4][$];
    beat_t       exq[$];

    turf_event_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .memclk(memclk), .memresetn(memresetn),
        .s_thdr_tdata(s_thdr_tdata), .s_thdr_tvalid(s_thdr_tvalid),
        .s_thdr_tready(s_thdr_tready), .s_thdr_tlast(s_thdr_tlast),
        .s_tio_tdata(s_tio_tdata), .s_tio_tvalid(s_tio_tvalid),
        .s_tio_tready(s_tio_tready), .s_tio_tlast(s_tio_tlast),
        .tio_mask_i(tio_mask_i),
        .m_ev_tdata(m_ev_tdata), .m_ev_tvalid(m_ev_tvalid),
        .m_ev_tready(m_ev_tready), .m_ev_tlast(m_ev_tlast),
        .busy_o(busy_o), .event_count_o(event_count_o), .tio_timeout_o(tio_timeout_o)
    );

    always #5 memclk = ~memclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        s_thdr_tvalid = 1'b0;
        s_thdr_tlast  = 1'b0;
        s_thdr_tdata  = '0;
        s_tio_tvalid  = 4'b0000;
        s_tio_tlast   = 4'b0000;
        s_tio_tdata   = '0;
        m_ev_tready   = 1'b0;
    endtask

    // One event: build sources + expected queue, then run cycle by cycle.
    // dead >= 0 names a TURFIO that never asserts tvalid; abort_at >= 0 stops
    // after that many output beats (used for the mid-event reset).
    task automatic run_event(input logic [3:0] mask, input int hlen, input int tlen,
                             input int p_valid, input int p_ready, input int dead,
                             input int abort_at, output int cycles);
        int          last;
        int          got;
        int          streak[5];
        logic [63:0] d;
        logic        v;
        beat_t       b;
        hq.delete();
        exq.delete();
        for (int n = 0; n < 4; n++) tq[n].delete();
        last = -1;
        for (int n = 0; n < 4; n++) if (!mask[n]) last = n;
        for (int i = 0; i < hlen; i++) begin
            d = {$urandom, $urandom};
            hq.push_back(d);
            exq.push_back('{d: d, l: (i == hlen - 1) && (mask == 4'hF)});
        end
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < tlen; j++) begin
                d = {$urandom, $urandom};
                tq[n].push_back(d);
                if (!mask[n] && n != dead)
                    exq.push_back('{d: d, l: (n == last) && (j == tlen - 1)});
            end
            if (!mask[n] && n == dead)
                exq.push_back('{d: 64'hBADD_0000_0000_0000 | 64'(n), l: (n == last)});
        end
        tio_mask_i = mask;
        for (int n = 0; n < 5; n++) streak[n] = 0;
        got    = 0;
        cycles = 0;
        while (exq.size() > 0 && cycles < 2000 && !(abort_at >= 0 && got >= abort_at)) begin
            @(negedge memclk);
            // Drive sources; a source idle 3 cycles is forced valid so the
            // watchdog never fires on a live source.
            v = (hq.size() > 0) && (($urandom_range(99) < p_valid) || streak[4] >= 3);
            s_thdr_tvalid = v;
            s_thdr_tdata  = (hq.size() > 0) ? hq[0] : '0;
            s_thdr_tlast  = (hq.size() == 1);
            streak[4]     = v ? 0 : streak[4] + 1;
            for (int n = 0; n < 4; n++) begin
                v = (tq[n].size() > 0) && (n != dead) &&
                    (($urandom_range(99) < p_valid) || streak[n] >= 3);
                s_tio_tvalid[n]           = v;
                s_tio_tdata[n*DW +: DW]   = (tq[n].size() > 0) ? tq[n][0] : '0;
                s_tio_tlast[n]            = (tq[n].size() == 1);
                streak[n]                 = v ? 0 : streak[n] + 1;
            end
            m_ev_tready = ($urandom_range(99) < p_ready);
            #1;
            for (int n = 0; n < 4; n++)
                if (mask[n]) chk($sformatf("masked_tready%0d", n), 64'(s_tio_tready[n]), 64'd0);
            if (got > 0) chk("busy_mid_event", 64'(busy_o), 64'd1);
            if (m_ev_tvalid && m_ev_tready) begin
                b = exq.pop_front();
                chk($sformatf("beat%0d_data", got), m_ev_tdata, b.d);
                chk($sformatf("beat%0d_tlast", got), 64'(m_ev_tlast), 64'(b.l));
                if (b.l) exp_count++;
                got++;
            end
            if (s_thdr_tvalid && s_thdr_tready) void'(hq.pop_front());
            for (int n = 0; n < 4; n++)
                if (s_tio_tvalid[n] && s_tio_tready[n]) void'(tq[n].pop_front());
            cycles++;
        end
        if (abort_at < 0) begin
            chk("event_complete_remaining", 64'(exq.size()), 64'd0);
            @(negedge memclk);
            idle_inputs();
            #1;
            chk("event_count", 64'(event_count_o), 64'(exp_count));
            chk("busy_after_event", 64'(busy_o), 64'd0);
            chk("hdr_drained", 64'(hq.size()), 64'd0);
            for (int n = 0; n < 4; n++)
                if (!mask[n] && n != dead)
                    chk($sformatf("tio%0d_drained", n), 64'(tq[n].size()), 64'd0);
        end
        $display("event mask=%b hlen=%0d tlen=%0d beats_out=%0d cycles=%0d count=%0d",
                 mask, hlen, tlen, got, cycles, event_count_o);
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] m;
        int         h;
        int         t;
        idle_inputs();
        tio_mask_i = 4'h0;
        memresetn  = 1'b0;
        repeat (2) @(negedge memclk);
        m_ev_tready   = 1'b1;
        s_thdr_tvalid = 1'b1;
        #1;
        chk("rst_m_ev_tvalid", 64'(m_ev_tvalid), 64'd0);
        chk("rst_m_ev_tlast", 64'(m_ev_tlast), 64'd0);
        chk("rst_m_ev_tdata", m_ev_tdata, 64'd0);
        chk("rst_thdr_tready", 64'(s_thdr_tready), 64'd0);
        chk("rst_tio_tready", 64'(s_tio_tready), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_event_count", 64'(event_count_o), 64'd0);
        chk("rst_timeout", 64'(tio_timeout_o), 64'd0);
        @(negedge memclk);
        idle_inputs();
        memresetn = 1'b1;

        // Full event, no stalls: 28 beats in 28 cycles
        run_event(4'h0, 16, 3, 100, 100, -1, -1, cyc);
        chk("full_rate_cycles", 64'(cyc), 64'd28);
        // Sparse mask: header, T1, T3
        run_event(4'b0101, 16, 3, 100, 100, -1, -1, cyc);
        chk("mask0101_cycles", 64'(cyc), 64'd22);
        // All masked: header only with its tlast forwarded
        run_event(4'hF, 16, 3, 100, 100, -1, -1, cyc);
        // Single-beat headers: tlast decided on the IDLE acceptance beat
        run_event(4'hF, 1, 2, 100, 100, -1, -1, cyc);
        run_event(4'b1110, 1, 2, 60, 60, -1, -1, cyc);
        // Random backpressure and source validity
        for (int e = 0; e < 8; e++) begin
            m = 4'($urandom_range(15));
            h = $urandom_range(1, 8);
            t = $urandom_range(1, 4);
            run_event(m, h, t, 50, 50, -1, -1, cyc);
        end

        // Reset for one cycle during T1
        run_event(4'h0, 4, 3, 70, 70, -1, 8, cyc);
        @(negedge memclk);
        memresetn     = 1'b0;
        m_ev_tready   = 1'b1;
        s_thdr_tvalid = 1'b1;
        s_thdr_tdata  = 64'h1234;
        s_tio_tvalid  = 4'hF;
        #1;
        chk("midrst_m_ev_tvalid", 64'(m_ev_tvalid), 64'd0);
        chk("midrst_m_ev_tdata", m_ev_tdata, 64'd0);
        chk("midrst_tio_tready", 64'(s_tio_tready), 64'd0);
        chk("midrst_thdr_tready", 64'(s_thdr_tready), 64'd0);
        @(negedge memclk);
        memresetn = 1'b1;
        idle_inputs();
        exp_count = 0;
        #1;
        chk("postrst_event_count", 64'(event_count_o), 64'd0);
        chk("postrst_busy", 64'(busy_o), 64'd0);
        chk("postrst_m_ev_tvalid", 64'(m_ev_tvalid), 64'd0);
        chk("postrst_m_ev_tlast", 64'(m_ev_tlast), 64'd0);
        run_event(4'h0, 5, 3, 50, 50, -1, -1, cyc);

`ifdef EVENT_SEQ_TIMEOUT_EN
        // T3 never valid: 8 idle cycles then the fill beat with tlast
        run_event(4'h0, 3, 2, 100, 100, 3, -1, cyc);
        chk("timeout_cycles", 64'(cyc), 64'd18);
        chk("timeout_flags", 64'(tio_timeout_o), 64'h8);
`else
        chk("timeout_flags_off", 64'(tio_timeout_o), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
